// File: rtl/sensor_conditioner.sv
// sensor_conditioner: turns two raw photocell beams into clean arrival/departure pulses,
// with synchronisation, debouncing, stuck-beam detection and full/empty gating.
`default_nettype none

module sensor_channel #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned STUCK    = 255
) (
  input  logic clock,
  input  logic clear_flags,
  input  logic raw,
  input  logic gate,
  output logic pass_pulse,
  output logic drop_pulse,
  output logic fault
);

  localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE - 1);
  localparam logic [7:0] STUCK_LAST = 8'(STUCK - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BLOCKED = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  logic       sync1;
  logic       sync2;
  logic       level;
  logic [3:0] db_cnt;
  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] stuck_cnt;
  logic       stuck_hit;
  logic       candidate;

  always_ff @(posedge clock) begin
    if (clear_flags) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (clear_flags) begin
      level  <= 1'b0;
      db_cnt <= 4'd0;
    end else if (sync2 != level) begin
      if (db_cnt == DB_LAST) begin
        level  <= ~level;
        db_cnt <= 4'd0;
      end else begin
        db_cnt <= db_cnt + 4'd1;
      end
    end else begin
      db_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear_flags) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Held at zero outside BLOCKED, so it starts from zero on every entry.
  always_ff @(posedge clock) begin
    if (clear_flags || state != ST_BLOCKED) begin
      stuck_cnt <= 8'd0;
    end else begin
      stuck_cnt <= stuck_cnt + 8'd1;
    end
  end

  assign stuck_hit = (stuck_cnt == STUCK_LAST);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (level) state_next = ST_BLOCKED;
      end
      ST_BLOCKED: begin
        if (!level)         state_next = ST_IDLE;
        else if (stuck_hit) state_next = ST_FAULT;
      end
      ST_FAULT: begin
        if (!level) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fault     = (state == ST_FAULT);
    candidate = (state == ST_BLOCKED) && !level;
  end

  always_ff @(posedge clock) begin
    if (clear_flags) begin
      pass_pulse <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      pass_pulse <= candidate & ~gate;
      drop_pulse <= candidate & gate;
    end
  end

endmodule

module sensor_conditioner #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned STUCK    = 255
) (
  input  logic clock,
  input  logic clear_flags,
  input  logic bph_raw,
  input  logic fph_raw,
  input  logic full,
  input  logic empty,
  output logic BPH,
  output logic FPH,
  output logic reject,
  output logic underflow,
  output logic fault_b,
  output logic fault_f
);

  // Back arrivals are gated by full, front departures by empty.
  sensor_channel #(
    .DEBOUNCE (DEBOUNCE),
    .STUCK    (STUCK)
  ) u_back (
    .clock       (clock),
    .clear_flags (clear_flags),
    .raw         (bph_raw),
    .gate        (full),
    .pass_pulse  (BPH),
    .drop_pulse  (reject),
    .fault       (fault_b)
  );

  sensor_channel #(
    .DEBOUNCE (DEBOUNCE),
    .STUCK    (STUCK)
  ) u_front (
    .clock       (clock),
    .clear_flags (clear_flags),
    .raw         (fph_raw),
    .gate        (empty),
    .pass_pulse  (FPH),
    .drop_pulse  (underflow),
    .fault       (fault_f)
  );

endmodule

`default_nettype wire

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter: DEBOUNCE, default 4, consecutive stable cycles (1..15) required to accept a sensor level change.
REQ-002 Parameter: STUCK, default 255, cycles (1..255) a beam may stay blocked before a fault is declared.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 clear_flags  input  1  reset, synchronous, active-high.
REQ-005 bph_raw  input  1  back photocell, asynchronous, 1 = beam blocked (customer entering queue).
REQ-006 fph_raw  input  1  front photocell, asynchronous, 1 = beam blocked (customer leaving to teller).
REQ-007 full  input  1  queue-full flag from the customer counter.
REQ-008 empty  input  1  queue-empty flag from the customer counter.
REQ-009 BPH  output  1  one-cycle arrival pulse to the customer counter.
REQ-010 FPH  output  1  one-cycle departure pulse to the customer counter.
REQ-011 reject  output  1  one-cycle pulse: arrival discarded because full.
REQ-012 underflow  output  1  one-cycle pulse: departure discarded because empty.
REQ-013 fault_b / fault_f  output  1 each  level: back / front beam stuck blocked.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer; synchronized value s lags raw by 2 edges.
REQ-015 Each channel SHALL hold a debounced level d and 4-bit mismatch counter: counter increments while s != d, clears while s == d; d toggles and the counter clears on the edge the count reaches DEBOUNCE.
REQ-016 A glitch shorter than DEBOUNCE synchronized cycles SHALL never change d.
REQ-017 Each channel SHALL run FSM IDLE / BLOCKED / FAULT, reset state IDLE.
REQ-018 IDLE -> BLOCKED when d rises; 8-bit stuck counter cleared on entry.
REQ-019 BLOCKED -> IDLE when d falls; a candidate event is raised on that transition (customer fully passed the beam).
REQ-020 BLOCKED: stuck counter increments each cycle; on reaching STUCK -> FAULT, no event.
REQ-021 FAULT: fault_x = 1; FAULT -> IDLE when d falls, no event generated, fault_x drops on the same edge.
REQ-022 Back candidate: BPH = 1 for one cycle if full = 0, else reject = 1 for one cycle; BPH and reject never both high.
REQ-023 Front candidate: FPH = 1 for one cycle if empty = 0, else underflow = 1 for one cycle.
REQ-024 full/empty SHALL be sampled in the same cycle the candidate is raised; all pulses registered, asserted on the edge after d falls.
REQ-025 Raw-fall to pulse latency SHALL be exactly DEBOUNCE+3 cycles for a clean edge.
REQ-026 Back and front channels are independent; simultaneous BPH and FPH in one cycle SHALL both be issued.
REQ-027 A sensor held blocked through reset SHALL, after reset release, debounce to BLOCKED and produce a pulse only on subsequent clearing.

Reset
REQ-028 On clear_flags = 1 at a rising edge: synchronizers, d, all counters to 0; FSMs to IDLE; BPH, FPH, reject, underflow, fault_b, fault_f to 0.
REQ-029 Reset mid-BLOCKED or mid-FAULT SHALL drop any pending event and fault without emitting a pulse.

Verification (DEBOUNCE = 4, STUCK = 20)
REQ-030 bph_raw high 10 cycles then low, full = 0 -> one BPH pulse exactly 7 cycles after the fall; no other outputs.
REQ-031 bph_raw 3-cycle high glitch -> no BPH, FSM stays IDLE.
REQ-032 bph_raw pass with full = 1 -> reject pulse 7 cycles after fall, BPH stays 0; same on fph_raw with empty = 1 -> underflow only.
REQ-033 fph_raw held high 40 cycles -> fault_f = 1 starting 21 cycles after d rises; on release fault_f clears, no FPH.
REQ-034 bph_raw and fph_raw identical passes in lockstep -> BPH and FPH high on the same cycle.
REQ-035 clear_flags asserted while bph_raw blocked, released while still blocked -> no pulse until bph_raw falls, then single BPH.
